// File: rtl/data_ram_responder_pkg.sv
// Shared constants and helpers for the data SRAM responder: MMIO register
// offsets, address region type and the byte-lane merge used by every writable word.
package data_ram_params;

   localparam logic [1:0] OFFSET_LED     = 2'd0;
   localparam logic [1:0] OFFSET_SWITCH  = 2'd1;
   localparam logic [1:0] OFFSET_COUNTER = 2'd2;
   localparam logic [1:0] OFFSET_SCRATCH = 2'd3;

   typedef enum logic {
      REGION_RAM  = 1'b0,
      REGION_MMIO = 1'b1
   } region_t;

   // Lanes with a set strobe take the update byte, the rest keep the current byte.
   function automatic logic [31:0] lane_merge(input logic [31:0] current,
                                              input logic [31:0] update,
                                              input logic [3:0]  strobe);
      logic [31:0] merged;
      merged = current;
      for (int i = 0; i < 4; i++) begin
         if (strobe[i]) merged[8*i +: 8] = update[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/data_ram_responder_ram.sv
// Single-port synchronous RAM with four byte write strobes; read-first, so a
// write cycle returns the word's contents from before the write.
module byte_enable_ram #(
   parameter int ADDR_WIDTH = 14
) (
   input  logic                  clock,
   input  logic                  enable,
   input  logic [3:0]            write_strobe,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [31:0]           write_data,
   output logic [31:0]           read_data
);

   logic [31:0] memory [2**ADDR_WIDTH];

   always_ff @(posedge clock) begin
      if (enable) begin
         read_data <= memory[address];
         for (int i = 0; i < 4; i++) begin
            if (write_strobe[i]) memory[address][8*i +: 8] <= write_data[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/data_ram_responder.sv
// Responder on the core's data SRAM port: byte-writable word RAM plus a
// 16-byte register window (LED, SWITCH, COUNTER, SCRATCH), one-cycle read latency.
module data_ram_responder
   import data_ram_params::*;
#(
   parameter int          RAM_ADDR_WIDTH = 14,
   parameter logic [31:0] MMIO_BASE      = 32'hbfaf_f000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        data_enabled,
   input  logic [3:0]  data_write_enabled,
   input  logic [31:0] data_address,
   input  logic [31:0] data_write_data,
   output logic [31:0] data_read_data,
   input  logic [7:0]  switch_in,
   output logic [15:0] led_out,
   output logic        access_error
);

   region_t                   region_p0;
   region_t                   region_p1;
   logic                      vld_p0;
   logic                      vld_p1;
   logic                      is_write_p0;
   logic [1:0]                offset_p0;
   logic [RAM_ADDR_WIDTH-1:0] ram_index_p0;
   logic                      ram_enable_p0;
   logic [31:0]               ram_read_data_p1;

   logic [15:0]               led_reg;
   logic [7:0]                switch_meta;
   logic [7:0]                switch_sync;
   logic [31:0]               counter_reg;
   logic [31:0]               scratch_reg;

   logic                      led_write_p0;
   logic                      counter_write_p0;
   logic                      scratch_write_p0;
   logic                      switch_write_p0;
   logic [31:0]               led_merged_p0;
   logic [31:0]               mmio_read_p0;
   logic [31:0]               mmio_read_data_p1;
   logic                      unused_bits;

   // Stage p0: decode the request; a request seen during reset is dropped.
   assign vld_p0        = data_enabled & ~reset;
   assign is_write_p0   = |data_write_enabled;
   assign region_p0     = (data_address[31:4] == MMIO_BASE[31:4]) ? REGION_MMIO : REGION_RAM;
   assign offset_p0     = data_address[3:2];
   assign ram_index_p0  = data_address[RAM_ADDR_WIDTH+1:2];
   assign ram_enable_p0 = vld_p0 && (region_p0 == REGION_RAM);

   assign led_write_p0     = vld_p0 && is_write_p0 && (region_p0 == REGION_MMIO) && (offset_p0 == OFFSET_LED);
   assign switch_write_p0  = vld_p0 && is_write_p0 && (region_p0 == REGION_MMIO) && (offset_p0 == OFFSET_SWITCH);
   assign counter_write_p0 = vld_p0 && is_write_p0 && (region_p0 == REGION_MMIO) && (offset_p0 == OFFSET_COUNTER);
   assign scratch_write_p0 = vld_p0 && is_write_p0 && (region_p0 == REGION_MMIO) && (offset_p0 == OFFSET_SCRATCH);

   assign led_merged_p0 = lane_merge({16'h0000, led_reg}, data_write_data, data_write_enabled);
   assign unused_bits   = ^{data_address[1:0], led_merged_p0[31:16]};

   always_comb begin
      mmio_read_p0 = 32'h0000_0000;
      case (offset_p0)
         OFFSET_LED:     mmio_read_p0 = {16'h0000, led_reg};
         OFFSET_SWITCH:  mmio_read_p0 = {24'h00_0000, switch_sync};
         OFFSET_COUNTER: mmio_read_p0 = counter_reg;
         OFFSET_SCRATCH: mmio_read_p0 = scratch_reg;
         default:        mmio_read_p0 = 32'h0000_0000;
      endcase
   end

   byte_enable_ram #(
      .ADDR_WIDTH (RAM_ADDR_WIDTH)
   ) u_ram (
      .clock        (clock),
      .enable       (ram_enable_p0),
      .write_strobe (data_write_enabled),
      .address      (ram_index_p0),
      .write_data   (data_write_data),
      .read_data    (ram_read_data_p1)
   );

   // Stage p1: register state and the MMIO read word.
   always_ff @(posedge clock) begin
      if (reset) begin
         vld_p1       <= 1'b0;
         region_p1    <= REGION_RAM;
         led_reg      <= 16'h0000;
         switch_meta  <= 8'h00;
         switch_sync  <= 8'h00;
         counter_reg  <= 32'h0000_0000;
         scratch_reg  <= 32'h0000_0000;
         access_error <= 1'b0;
      end else begin
         switch_meta <= switch_in;
         switch_sync <= switch_meta;
         counter_reg <= counter_write_p0
                        ? lane_merge(counter_reg, data_write_data, data_write_enabled)
                        : counter_reg + 32'd1;
         if (led_write_p0)     led_reg      <= led_merged_p0[15:0];
         if (scratch_write_p0) scratch_reg  <= lane_merge(scratch_reg, data_write_data, data_write_enabled);
         if (switch_write_p0)  access_error <= 1'b1;
         if (vld_p0) begin
            vld_p1    <= 1'b1;
            region_p1 <= region_p0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (vld_p0 && (region_p0 == REGION_MMIO)) mmio_read_data_p1 <= mmio_read_p0;
   end

   // Output is zero until the first accepted request after reset, then holds.
   assign data_read_data = !vld_p1                   ? 32'h0000_0000 :
                           (region_p1 == REGION_MMIO) ? mmio_read_data_p1 : ram_read_data_p1;
   assign led_out        = led_reg;

endmodule

// File: tb/tb_data_ram_responder.sv
// Scenario bench for data_ram_responder: expected read words are queued as each
// request is driven and compared against the word captured after its edge.
module tb_data_ram_responder;

   localparam logic [31:0] MB = 32'hbfaf_f000;

   logic        clock = 1'b0;
   logic        reset;
   logic        data_enabled;
   logic [3:0]  data_write_enabled;
   logic [31:0] data_address;
   logic [31:0] data_write_data;
   logic [31:0] data_read_data;
   logic [7:0]  switch_in;
   logic [15:0] led_out;
   logic        access_error;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string       name;
      logic [31:0] value;
      bit          known;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] obs_q[$];

   data_ram_responder dut (
      .clock              (clock),
      .reset              (reset),
      .data_enabled       (data_enabled),
      .data_write_enabled (data_write_enabled),
      .data_address       (data_address),
      .data_write_data    (data_write_data),
      .data_read_data     (data_read_data),
      .switch_in          (switch_in),
      .led_out            (led_out),
      .access_error       (access_error)
   );

   always #5 clock = ~clock;

   task automatic drive(input logic en, input logic [3:0] we, input logic [31:0] addr,
                        input logic [31:0] wd, input string name,
                        input logic [31:0] exp_val, input bit known);
      exp_t e;
      e.name  = name;
      e.value = exp_val;
      e.known = known;
      exp_q.push_back(e);
      data_enabled       = en;
      data_write_enabled = we;
      data_address       = addr;
      data_write_data    = wd;
      @(posedge clock);
      #1;
      obs_q.push_back(data_read_data);
      data_enabled       = 1'b0;
      data_write_enabled = 4'h0;
   endtask

   task automatic test_reset();
      exp_t e;
      logic [31:0] o;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (data_read_data !== 32'h0) begin errors++; $display("FAIL reset_read_data: got %h want %h", data_read_data, 32'h0); end
      checks++;
      if (led_out !== 16'h0) begin errors++; $display("FAIL reset_led: got %h want %h", led_out, 16'h0); end
      checks++;
      if (access_error !== 1'b0) begin errors++; $display("FAIL reset_access_error: got %b want 0", access_error); end
      reset = 1'b0;
      drive(1, 4'h0, MB + 32'h8, 32'h0, "counter_after_reset", 32'h0000_0000, 1);
      drive(1, 4'h0, MB + 32'hc, 32'h0, "scratch_after_reset", 32'h0000_0000, 1);
      drive(1, 4'h0, MB + 32'h4, 32'h0, "switch_after_reset",  32'h0000_0000, 1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         if (e.known) begin
            checks++;
            if (o !== e.value) begin errors++; $display("FAIL %s: got %h want %h", e.name, o, e.value); end
         end
      end
   endtask

   task automatic test_ram();
      exp_t e;
      logic [31:0] o;
      drive(1, 4'hf,    32'h0000_0100, 32'hdead_beef, "ram_first_write", 32'h0, 0);
      drive(1, 4'h0,    32'h0000_0100, 32'h0,         "ram_read_full",   32'hdead_beef, 1);
      drive(1, 4'b0101, 32'h0000_0100, 32'h1122_3344, "ram_read_first",  32'hdead_beef, 1);
      drive(1, 4'h0,    32'h0000_0100, 32'h0,         "ram_read_merged", 32'hde22_be44, 1);
      drive(0, 4'h0,    32'h0000_0000, 32'h0,         "ram_idle_hold",   32'hde22_be44, 1);
      drive(1, 4'h0,    32'h0001_0103, 32'h0,         "ram_alias_read",  32'hde22_be44, 1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         if (e.known) begin
            checks++;
            if (o !== e.value) begin errors++; $display("FAIL %s: got %h want %h", e.name, o, e.value); end
         end
      end
   endtask

   task automatic test_led();
      exp_t e;
      logic [31:0] o;
      drive(1, 4'hf, MB, 32'hffff_a5a5, "led_write_old", 32'h0000_0000, 1);
      checks++;
      if (led_out !== 16'ha5a5) begin errors++; $display("FAIL led_out_full: got %h want %h", led_out, 16'ha5a5); end
      drive(1, 4'h0,    MB, 32'h0,         "led_read",         32'h0000_a5a5, 1);
      drive(1, 4'b0010, MB, 32'h0000_3c00, "led_lane1_write",  32'h0000_a5a5, 1);
      checks++;
      if (led_out !== 16'h3ca5) begin errors++; $display("FAIL led_out_lane1: got %h want %h", led_out, 16'h3ca5); end
      drive(1, 4'b1100, MB, 32'h1234_0000, "led_upper_write",  32'h0000_3ca5, 1);
      drive(1, 4'h0,    MB, 32'h0,         "led_upper_read",   32'h0000_3ca5, 1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         if (e.known) begin
            checks++;
            if (o !== e.value) begin errors++; $display("FAIL %s: got %h want %h", e.name, o, e.value); end
         end
      end
   endtask

   task automatic test_counter_scratch();
      exp_t e;
      logic [31:0] o;
      drive(1, 4'hf,    MB + 32'h8, 32'hffff_fffe, "counter_write",     32'h0, 0);
      drive(0, 4'h0,    MB + 32'h8, 32'h0,         "counter_idle",      32'h0, 0);
      drive(1, 4'h0,    MB + 32'h8, 32'h0,         "counter_max",       32'hffff_ffff, 1);
      drive(1, 4'h0,    MB + 32'h8, 32'h0,         "counter_wrap",      32'h0000_0000, 1);
      drive(1, 4'h0,    MB + 32'h8, 32'h0,         "counter_after",     32'h0000_0001, 1);
      drive(1, 4'hf,    MB + 32'hc, 32'h1234_5678, "scratch_write_old", 32'h0000_0000, 1);
      drive(1, 4'h0,    MB + 32'hc, 32'h0,         "scratch_read",      32'h1234_5678, 1);
      drive(1, 4'b1000, MB + 32'hc, 32'haa00_0000, "scratch_lane3",     32'h1234_5678, 1);
      drive(1, 4'h0,    MB + 32'hf, 32'h0,         "scratch_merged",    32'haa34_5678, 1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         if (e.known) begin
            checks++;
            if (o !== e.value) begin errors++; $display("FAIL %s: got %h want %h", e.name, o, e.value); end
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      logic [31:0] o;
      drive(1, 4'hf, 32'h0000_0200, 32'ha0a0_a0a0, "b2b_write_a",  32'h0, 0);
      drive(1, 4'hf, 32'h0000_0204, 32'hb1b1_b1b1, "b2b_write_b",  32'h0, 0);
      drive(1, 4'h0, 32'h0000_0200, 32'h0,         "b2b_read_a",   32'ha0a0_a0a0, 1);
      drive(1, 4'h0, 32'h0000_0204, 32'h0,         "b2b_read_b",   32'hb1b1_b1b1, 1);
      drive(1, 4'hf, 32'h0000_0200, 32'hc2c2_c2c2, "b2b_write_c",  32'ha0a0_a0a0, 1);
      drive(1, 4'h0, 32'h0000_0200, 32'h0,         "b2b_read_c",   32'hc2c2_c2c2, 1);
      drive(1, 4'h0, MB + 32'hc,    32'h0,         "b2b_mmio",     32'haa34_5678, 1);
      drive(1, 4'h0, 32'h0000_0204, 32'h0,         "b2b_back_ram", 32'hb1b1_b1b1, 1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         if (e.known) begin
            checks++;
            if (o !== e.value) begin errors++; $display("FAIL %s: got %h want %h", e.name, o, e.value); end
         end
      end
   endtask

   task automatic test_switch();
      exp_t e;
      logic [31:0] o;
      switch_in = 8'h3c;
      drive(1, 4'h0, MB + 32'h4, 32'h0,         "switch_sync_1",  32'h0000_0000, 1);
      drive(1, 4'h0, MB + 32'h4, 32'h0,         "switch_sync_2",  32'h0000_0000, 1);
      drive(1, 4'h0, MB + 32'h4, 32'h0,         "switch_visible", 32'h0000_003c, 1);
      checks++;
      if (access_error !== 1'b0) begin errors++; $display("FAIL access_error_before: got %b want 0", access_error); end
      drive(1, 4'hf, MB + 32'h4, 32'hffff_ffff, "switch_write",   32'h0000_003c, 1);
      checks++;
      if (access_error !== 1'b1) begin errors++; $display("FAIL access_error_set: got %b want 1", access_error); end
      drive(0, 4'h0, 32'h0,      32'h0,         "switch_hold",    32'h0000_003c, 1);
      drive(1, 4'h0, 32'h0000_0200, 32'h0,      "ram_after_err",  32'hc2c2_c2c2, 1);
      drive(1, 4'h0, MB + 32'h4, 32'h0,         "switch_kept",    32'h0000_003c, 1);
      checks++;
      if (access_error !== 1'b1) begin errors++; $display("FAIL access_error_sticky: got %b want 1", access_error); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         if (e.known) begin
            checks++;
            if (o !== e.value) begin errors++; $display("FAIL %s: got %h want %h", e.name, o, e.value); end
         end
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      logic [31:0] o;
      drive(1, 4'hf, 32'h0000_0300, 32'h55aa_55aa, "mid_prewrite", 32'h0, 0);
      drive(1, 4'hf, MB + 32'hc,    32'h0bad_f00d, "mid_scratch",  32'haa34_5678, 1);
      reset              = 1'b1;
      data_enabled       = 1'b1;
      data_write_enabled = 4'hf;
      data_address       = 32'h0000_0300;
      data_write_data    = 32'hffff_ffff;
      @(posedge clock);
      #1;
      reset              = 1'b0;
      data_enabled       = 1'b0;
      data_write_enabled = 4'h0;
      checks++;
      if (data_read_data !== 32'h0) begin errors++; $display("FAIL mid_reset_read_data: got %h want %h", data_read_data, 32'h0); end
      checks++;
      if (led_out !== 16'h0) begin errors++; $display("FAIL mid_reset_led: got %h want %h", led_out, 16'h0); end
      checks++;
      if (access_error !== 1'b0) begin errors++; $display("FAIL mid_reset_access_error: got %b want 0", access_error); end
      drive(1, 4'h0, MB + 32'h8,    32'h0, "mid_counter_zero", 32'h0000_0000, 1);
      drive(1, 4'h0, 32'h0000_0300, 32'h0, "mid_ram_kept",     32'h55aa_55aa, 1);
      drive(1, 4'h0, MB + 32'hc,    32'h0, "mid_scratch_zero", 32'h0000_0000, 1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         if (e.known) begin
            checks++;
            if (o !== e.value) begin errors++; $display("FAIL %s: got %h want %h", e.name, o, e.value); end
         end
      end
   endtask

   initial begin
      reset              = 1'b1;
      data_enabled       = 1'b0;
      data_write_enabled = 4'h0;
      data_address       = 32'h0;
      data_write_data    = 32'h0;
      switch_in          = 8'h00;
      test_reset();
      test_ram();
      test_led();
      test_counter_scratch();
      test_back_to_back();
      test_switch();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
